// File: rtl/correlator_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier among N_REQ lanes.
// Credit-based issue keeps every tagged product safe in the output FIFO under backpressure.
module correlator_mul_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DW         = 16,
  parameter int MUL_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*DW-1:0]   req_a,
  input  logic [N_REQ*DW-1:0]   req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*DW-1:0]       res_data,
  output logic [IDW-1:0]        res_id,
  output logic                  busy
);

  localparam int              OCW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [OCW-1:0]  DEPTH_O = OCW'(FIFO_DEPTH);
  localparam logic [OCW:0]    DEPTH_U = (OCW + 1)'(FIFO_DEPTH);
  localparam logic [IDW-1:0]  LAST_ID = IDW'(N_REQ - 1);

  logic                   r_rst_meta, r_rst_sync;
  logic [IDW-1:0]         r_rr_ptr;
  logic [OCW-1:0]         r_occ, r_inflight;
  logic                   r_s1_v;
  logic signed [DW-1:0]   r_s1_a, r_s1_b;
  logic [IDW-1:0]         r_s1_id;
  logic [2*DW-1:0]        r_q_data [FIFO_DEPTH];
  logic [IDW-1:0]         r_q_id   [FIFO_DEPTH];

  logic                   w_found, w_has_credit, w_issue, w_pop;
  logic [IDW-1:0]         w_win;
  logic [OCW:0]           w_used;
  logic [2*DW-1:0]        w_prod;
  logic                   w_push;
  logic [2*DW-1:0]        w_push_data;
  logic [IDW-1:0]         w_push_id;
  logic [2*DW-1:0]        w_q_data [FIFO_DEPTH];
  logic [IDW-1:0]         w_q_id   [FIFO_DEPTH];
  int                     w_wr_idx;

  // Issue is held off until the synchronised release, so no state flop sees
  // a D different from its reset value while ap_rst_n deasserts asynchronously.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && req_valid[(int'(r_rr_ptr) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_win   = IDW'((int'(r_rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign w_used       = {1'b0, r_occ} + {1'b0, r_inflight};
  assign w_has_credit = (w_used < DEPTH_U);
  assign w_issue      = w_found & w_has_credit & r_rst_sync;
  assign req_ready    = w_issue ? (N_REQ'(1) << w_win) : '0;
  assign w_pop        = (r_occ != '0) & res_ready;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rr_ptr   <= '0;
      r_s1_v     <= 1'b0;
      r_occ      <= '0;
      r_inflight <= '0;
    end else begin
      r_s1_v     <= w_issue;
      r_occ      <= r_occ + OCW'(w_push) - OCW'(w_pop);
      r_inflight <= r_inflight + OCW'(w_issue) - OCW'(w_push);
      if (w_issue) r_rr_ptr <= (w_win == LAST_ID) ? '0 : w_win + 1'b1;
    end
  end

  // NOTE: pipeline datapath registers are not reset; their valid bits qualify them.
  always_ff @(posedge ap_clk) begin
    if (w_issue) begin
      r_s1_a  <= req_a[int'(w_win)*DW +: DW];
      r_s1_b  <= req_b[int'(w_win)*DW +: DW];
      r_s1_id <= w_win;
    end
  end

  assign w_prod = (2*DW)'(r_s1_a) * (2*DW)'(r_s1_b);

  generate
    if (MUL_LAT == 1) begin : g_lat1
      assign w_push      = r_s1_v;
      assign w_push_data = w_prod;
      assign w_push_id   = r_s1_id;
    end else begin : g_latn
      logic [MUL_LAT-2:0] r_pv;
      logic [2*DW-1:0]    r_pd  [MUL_LAT-1];
      logic [IDW-1:0]     r_pid [MUL_LAT-1];

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          r_pv <= '0;
        end else begin
          r_pv[0] <= r_s1_v;
          for (int i = 1; i < MUL_LAT - 1; i++) r_pv[i] <= r_pv[i-1];
        end
      end

      always_ff @(posedge ap_clk) begin
        r_pd[0]  <= w_prod;
        r_pid[0] <= r_s1_id;
        for (int i = 1; i < MUL_LAT - 1; i++) begin
          r_pd[i]  <= r_pd[i-1];
          r_pid[i] <= r_pid[i-1];
        end
      end

      assign w_push      = r_pv[MUL_LAT-2];
      assign w_push_data = r_pd[MUL_LAT-2];
      assign w_push_id   = r_pid[MUL_LAT-2];
    end
  endgenerate

  // Shift-register FIFO: entry 0 is always the head, so the outputs come straight from flops.
  assign w_wr_idx = int'(r_occ) - int'(w_pop);

  always_comb begin
    w_q_data = r_q_data;
    w_q_id   = r_q_id;
    if (w_pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        w_q_data[i] = r_q_data[i+1];
        w_q_id[i]   = r_q_id[i+1];
      end
    end
    if (w_push) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (i == w_wr_idx) begin
          w_q_data[i] = w_push_data;
          w_q_id[i]   = w_push_id;
        end
      end
    end
  end

  // NOTE: FIFO storage is reset because its head drives res_data/res_id directly.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_q_data[i] <= '0;
        r_q_id[i]   <= '0;
      end
    end else begin
      r_q_data <= w_q_data;
      r_q_id   <= w_q_id;
    end
  end

  assign res_valid = (r_occ != '0);
  assign res_data  = r_q_data[0];
  assign res_id    = r_q_id[0];
  assign busy      = (r_occ != '0) | (r_inflight != '0);

  always_ff @(posedge ap_clk) begin
    if (ap_rst_n) assert (!(w_push && !w_pop && (r_occ == DEPTH_O)));
  end

endmodule

// File: tb/tb_correlator_mul_arbiter.sv
// Directed bench for correlator_mul_arbiter: reset, latency, extreme product,
// round-robin streaming, backpressure with credit stall, and mid-operation reset.
module tb_correlator_mul_arbiter;
  localparam int N_REQ = 4, DW = 16, MUL_LAT = 2, FIFO_DEPTH = 4, IDW = 2;

  logic                ap_clk = 1'b0;
  logic                ap_rst_n = 1'b1;
  logic [N_REQ-1:0]    req_valid = '0;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*DW-1:0] req_a = '0;
  logic [N_REQ*DW-1:0] req_b = '0;
  logic                res_valid;
  logic                res_ready = 1'b0;
  logic [2*DW-1:0]     res_data;
  logic [IDW-1:0]      res_id;
  logic                busy;

  int total = 0;
  int bad   = 0;

  correlator_mul_arbiter #(
    .N_REQ(N_REQ), .DW(DW), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH), .IDW(IDW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_lane(input int i, input int a, input int b);
    req_a[i*DW +: DW] = DW'(a);
    req_b[i*DW +: DW] = DW'(b);
  endtask

  task automatic do_reset();
    ap_rst_n  = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    repeat (2) step();
    ap_rst_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    #1 ap_rst_n = 1'b0;
    req_valid = '1;
    res_ready = 1'b1;
    settle();
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (res_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", res_data); end
    total++; if (res_id !== 2'd0) begin bad++; $display("FAIL rst_id: got %0d want 0", res_id); end
    req_valid = '0;
    step();
    ap_rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      settle();
      total++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL idle_c%0d: got valid=%b busy=%b ready=%b want 0/0/0000", c, res_valid, busy, req_ready);
      end
      step();
    end
  endtask

  task automatic test_single();
    do_reset();
    set_lane(2, 300, -7);
    req_valid = 4'b0100;
    res_ready = 1'b1;
    settle();
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    step();
    req_valid = '0;
    for (int c = 1; c <= 2; c++) begin
      settle();
      total++;
      if (res_valid !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL single_wait%0d: got valid=%b busy=%b want 0/1", c, res_valid, busy);
      end
      step();
    end
    settle();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL single_lat: got valid=%b want 1", res_valid); end
    total++; if (res_data !== 32'hFFFFF7CC) begin bad++; $display("FAIL single_data: got %h want fffff7cc", res_data); end
    total++; if (res_id !== 2'd2) begin bad++; $display("FAIL single_id: got %0d want 2", res_id); end
    step();
    settle();
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_after_pop: got valid=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  task automatic test_extreme();
    do_reset();
    set_lane(0, -32768, -32768);
    req_valid = 4'b0001;
    res_ready = 1'b1;
    settle();
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL ext_grant: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    step();
    step();
    settle();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL ext_valid: got %b want 1", res_valid); end
    total++; if (res_data !== 32'h40000000) begin bad++; $display("FAIL ext_data: got %h want 40000000", res_data); end
    total++; if (res_id !== 2'd0) begin bad++; $display("FAIL ext_id: got %0d want 0", res_id); end
    step();
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] exp_ready;
    logic [IDW-1:0]   exp_id;
    logic [2*DW-1:0]  exp_data;
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_lane(i, i, 1);
    req_valid = 4'hF;
    res_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 8) req_valid = '0;
      settle();
      if (k < 8) begin
        exp_ready = 4'b0001 << (k % 4);
        total++;
        if (req_ready !== exp_ready) begin
          bad++;
          $display("FAIL rr_grant_k%0d: got %b want %b", k, req_ready, exp_ready);
        end
      end
      if (k >= 3 && k < 11) begin
        exp_id   = IDW'((k - 3) % 4);
        exp_data = 32'((k - 3) % 4);
        total++;
        if (res_valid !== 1'b1 || res_id !== exp_id || res_data !== exp_data) begin
          bad++;
          $display("FAIL rr_result_k%0d: got valid=%b id=%0d data=%0h want 1/%0d/%0h",
                   k, res_valid, res_id, res_data, exp_id, exp_data);
        end
      end else begin
        total++;
        if (res_valid !== 1'b0) begin bad++; $display("FAIL rr_novalid_k%0d: got %b want 0", k, res_valid); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int issues;
    int na0;
    int na1;
    int exp_d [4];
    logic [IDW-1:0] exp_i [4];
    logic [N_REQ-1:0] exp_ready;
    exp_d = '{3, 303, 6, 306};
    exp_i = '{2'd0, 2'd1, 2'd0, 2'd1};
    issues = 0;
    na0 = 1;
    na1 = 101;
    do_reset();
    set_lane(0, na0, 3);
    set_lane(1, na1, 3);
    req_valid = 4'b0011;
    res_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      settle();
      exp_ready = (c >= 4) ? 4'b0000 : ((c % 2 == 0) ? 4'b0001 : 4'b0010);
      total++;
      if (req_ready !== exp_ready) begin
        bad++;
        $display("FAIL bp_ready_c%0d: got %b want %b", c, req_ready, exp_ready);
      end
      if (c >= 4) begin
        total++;
        if (res_valid !== 1'b1 || res_data !== 32'd3 || res_id !== 2'd0) begin
          bad++;
          $display("FAIL bp_head_c%0d: got valid=%b data=%0d id=%0d want 1/3/0", c, res_valid, res_data, res_id);
        end
      end
      if (req_ready[0]) begin issues++; na0++; end
      if (req_ready[1]) begin issues++; na1++; end
      step();
      set_lane(0, na0, 3);
      set_lane(1, na1, 3);
    end
    total++; if (issues !== 4) begin bad++; $display("FAIL bp_issue_count: got %0d want 4", issues); end
    req_valid = '0;
    res_ready = 1'b1;
    for (int d = 0; d < 4; d++) begin
      settle();
      total++;
      if (res_valid !== 1'b1 || res_data !== 32'(exp_d[d]) || res_id !== exp_i[d]) begin
        bad++;
        $display("FAIL bp_drain_%0d: got valid=%b data=%0d id=%0d want 1/%0d/%0d",
                 d, res_valid, res_data, res_id, exp_d[d], exp_i[d]);
      end
      step();
    end
    settle();
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_empty: got valid=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_lane(0, 7, 7);
    set_lane(1, 7, 7);
    req_valid = 4'b0011;
    res_ready = 1'b0;
    repeat (4) step();
    settle();
    total++;
    if (res_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mr_pre: got valid=%b busy=%b want 1/1", res_valid, busy);
    end
    ap_rst_n = 1'b0;
    #1;
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL mr_async: got valid=%b busy=%b ready=%b want 0/0/0000", res_valid, busy, req_ready);
    end
    step();
    req_valid = '0;
    ap_rst_n  = 1'b1;
    res_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      total++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL mr_quiet_c%0d: got valid=%b busy=%b want 0/0", c, res_valid, busy);
      end
      step();
    end
    for (int i = 0; i < N_REQ; i++) set_lane(i, 5 + i, 5);
    req_valid = 4'hF;
    settle();
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mr_rr_ptr: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    for (int c = 1; c <= 2; c++) begin
      settle();
      total++;
      if (res_valid !== 1'b0) begin bad++; $display("FAIL mr_stale_%0d: got valid=%b want 0", c, res_valid); end
      step();
    end
    settle();
    total++;
    if (res_valid !== 1'b1 || res_data !== 32'd25 || res_id !== 2'd0) begin
      bad++;
      $display("FAIL mr_result: got valid=%b data=%0d id=%0d want 1/25/0", res_valid, res_data, res_id);
    end
    step();
    settle();
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mr_final: got valid=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_extreme();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
